// File: rtl/ppl_pkg.sv
// ppl_pkg
// Shared definitions for the IF/ID receiving end of the pipeline.
// Contents:
//   ppl_state_e       2-bit FSM state encodings (BOOT, RUN, HOLD)
//   PPL_NOP_INST      default bubble instruction word (MIPS sll $0,$0,0)
//   PPL_RESET_PC      default PC value loaded on reset
package ppl_pkg;

    // BOOT covers the single cycle after reset release, when the imem read
    // for RESET_PC is not yet trustworthy.
    // HOLD is entered while the hazard unit keeps stall asserted.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } ppl_state_e;

    localparam logic [31:0] PPL_NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PPL_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ppl_perf_cnt.sv
// PpL performance counter
// A CNT_W-bit counter that increments by one on each clock edge where
// en_i is high. It wraps modulo 2^CNT_W and never saturates.
// Ports:
//   clk      in   1      clock, updates on posedge
//   clrn     in   1      asynchronous active-low clear
//   en_i     in   1      count enable
//   cnt_o    out  CNT_W  current count
module ppl_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    // Free-running count; the natural overflow of the adder gives the wrap.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ppl_if_id_latch.sv
// ppl_if_id_latch
// Receiving end of the fetch stage. Owns the PC register that feeds fetch
// and the IF/ID latch that hands pc4/instruction to decode. Applies hazard
// unit stall (hold) and flush (bubble) requests, inserts one boot bubble
// after reset and keeps stall/flush/issue performance counters.
// Ports:
//   clk        in   1      clock, all state updates on posedge
//   clrn       in   1      asynchronous active-low reset
//   npc_f      in   32     next PC selected by fetch
//   pc4_f      in   32     fetch pc4
//   inst_f     in   32     fetch instruction word
//   stall      in   1      hold PC and IF/ID this cycle
//   flush      in   1      squash the instruction now in IF
//   pc_f       out  32     PC register, drives fetch pcIn
//   pc4_d      out  32     latched pc4 for decode
//   inst_d     out  32     latched instruction for decode
//   valid_d    out  1      1 = real instruction, 0 = bubble
//   stall_cnt  out  CNT_W  cycles with stall applied
//   flush_cnt  out  CNT_W  cycles with flush applied
//   issue_cnt  out  CNT_W  valid instructions latched
module ppl_if_id_latch
    import ppl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PPL_RESET_PC,
    parameter logic [31:0] NOP_INST = PPL_NOP_INST,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [31:0]      npc_f,
    input  logic [31:0]      pc4_f,
    input  logic [31:0]      inst_f,
    input  logic             stall,
    input  logic             flush,
    output logic [31:0]      pc_f,
    output logic [31:0]      pc4_d,
    output logic [31:0]      inst_d,
    output logic             valid_d,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] issue_cnt
);

    ppl_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] idPc4_q, idPc4_d;
    logic [31:0] idInst_q, idInst_d;
    logic        idValid_q, idValid_d;
    logic        stallEn, flushEn, issueEn;

    // Next-state logic for the FSM, PC and IF/ID latch. Everything holds by
    // default, so a stall only needs to bump its counter and pick HOLD.
    // RUN and HOLD share the same priority: flush, then stall, then advance.
    // Leaving HOLD applies the advance in the same cycle; because the PC was
    // held, fetch has re-read the same address and nothing is skipped.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        idPc4_d   = idPc4_q;
        idInst_d  = idInst_q;
        idValid_d = idValid_q;
        stallEn   = 1'b0;
        flushEn   = 1'b0;
        issueEn   = 1'b0;

        case (state_q)
            ST_BOOT: begin
                idInst_d  = NOP_INST;
                idValid_d = 1'b0;
                state_d   = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (flush) begin
                    pc_d      = npc_f;
                    idPc4_d   = pc4_f;
                    idInst_d  = NOP_INST;
                    idValid_d = 1'b0;
                    flushEn   = 1'b1;
                    state_d   = ST_RUN;
                end else if (stall) begin
                    stallEn   = 1'b1;
                    state_d   = ST_HOLD;
                end else begin
                    pc_d      = npc_f;
                    idPc4_d   = pc4_f;
                    idInst_d  = inst_f;
                    idValid_d = 1'b1;
                    issueEn   = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, PC and IF/ID registers. Reset forces a bubble into decode and
    // restarts through BOOT.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            idPc4_q   <= 32'h0000_0000;
            idInst_q  <= NOP_INST;
            idValid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            idPc4_q   <= idPc4_d;
            idInst_q  <= idInst_d;
            idValid_q <= idValid_d;
        end
    end

    ppl_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clrn  (clrn),
        .en_i  (stallEn),
        .cnt_o (stall_cnt)
    );

    ppl_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clrn  (clrn),
        .en_i  (flushEn),
        .cnt_o (flush_cnt)
    );

    ppl_perf_cnt #(.CNT_W(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .clrn  (clrn),
        .en_i  (issueEn),
        .cnt_o (issue_cnt)
    );

    assign pc_f    = pc_q;
    assign pc4_d   = idPc4_q;
    assign inst_d  = idInst_q;
    assign valid_d = idValid_q;

endmodule
